axis_multiseg_bram_reader: RTL and testbench

AXIS_MULTISEG_BRAM_READER -- requirements
Module: axis_multiseg_bram_reader

---
 rtl/axis_multiseg_pkg.sv | 8 +
 rtl/axis_skid_fifo3.sv | 47 ++++
 rtl/axis_multiseg_bram_reader.sv | 169 ++++++++++++++++
 tb/tb_axis_multiseg_bram_reader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/axis_multiseg_pkg.sv
// axis_multiseg_pkg: shared state encoding, buffer depth and pointer helper for the multi-segment BRAM reader.
package axis_multiseg_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;
  localparam int FIFO_DEPTH = 3;
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/axis_skid_fifo3.sv
// axis_skid_fifo3: 3-entry valid/ready output buffer with occupancy count.
module axis_skid_fifo3
  import axis_multiseg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [W-1:0] mem_d [FIFO_DEPTH];
  logic [1:0] wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d;
  logic push, pop;
  assign s_ready = cnt_q != 2'(FIFO_DEPTH);
  assign m_valid = cnt_q != 2'd0;
  assign m_data  = mem_q[rd_q];
  assign count   = cnt_q;
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = s_data;
    wr_d  = push ? ptr_inc(wr_q) : wr_q;
    rd_d  = pop ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/axis_multiseg_bram_reader.sv
// axis_multiseg_bram_reader: streams a table of BRAM address segments over AXI-Stream,
// with repeat/continuous passes, stop at segment boundaries and a run-complete token.
module axis_multiseg_bram_reader
  import axis_multiseg_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 10,
  parameter int NUM_SEG          = 4,
  parameter int REP_WIDTH        = 8,
  localparam int SEG_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [NUM_SEG*BRAM_ADDR_WIDTH-1:0] cfg_start,
  input  logic [NUM_SEG*BRAM_ADDR_WIDTH-1:0] cfg_end,
  input  logic [SEG_W:0]                     cfg_nseg,
  input  logic [REP_WIDTH-1:0]               cfg_repeat,
  input  logic                               cfg_continuous,
  input  logic                               trigger,
  input  logic                               stop,
  input  logic                               m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]        m_axis_tdata,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  output logic [SEG_W-1:0]                   m_axis_tuser,
  output logic                               m_axis_done_tvalid,
  input  logic                               m_axis_done_tready,
  output logic                               sts_busy,
  output logic [SEG_W-1:0]                   sts_seg,
  output logic [BRAM_ADDR_WIDTH-1:0]         sts_addr,
  output logic                               bram_porta_clk,
  output logic                               bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]         bram_porta_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]         bram_porta_rddata
);
  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int FW = BRAM_DATA_WIDTH + 1 + SEG_W;
  state_e state_q, state_d;
  logic [NUM_SEG*AW-1:0] start_q, start_d, end_q, end_d;
  logic [SEG_W:0] nseg_q, nseg_d;
  logic [REP_WIDTH-1:0] rep_q, rep_d;
  logic cont_q, cont_d, stop_q, stop_d;
  logic [SEG_W-1:0] seg_q, seg_d, s1_q, s1_d, s2_q, s2_d, nxt_seg;
  logic [AW-1:0] addr_q, addr_d, raddr_q, raddr_d, cur_start, cur_end, nxt_start;
  logic v1_q, v1_d, v2_q, v2_d, l1_q, l1_d, l2_q, l2_d;
  logic [FW-1:0] fifo_data;
  logic [1:0] fifo_cnt;
  logic [2:0] occ;
  logic fifo_valid, fifo_ready, pop, can_issue, seg_empty, at_end, last_seg, more;
  axis_skid_fifo3 #(.W(FW)) u_fifo (
    .aclk(aclk), .areset(areset),
    .s_data({bram_porta_rddata, l2_q, s2_q}), .s_valid(v2_q), .s_ready(fifo_ready),
    .m_data(fifo_data), .m_valid(fifo_valid), .m_ready(m_axis_tready),
    .count(fifo_cnt)
  );
  assign pop       = fifo_valid & m_axis_tready;
  // Occupancy after this cycle's pop, so a streaming consumer keeps the pipe full.
  assign occ       = {1'b0, fifo_cnt} - {2'b0, pop} + {2'b0, v1_q} + {2'b0, v2_q};
  assign can_issue = occ < 3'(FIFO_DEPTH) && (fifo_ready || pop);
  assign cur_start = start_q[int'(seg_q)*AW +: AW];
  assign cur_end   = end_q[int'(seg_q)*AW +: AW];
  assign seg_empty = cur_end < cur_start;
  assign at_end    = addr_q == cur_end;
  assign last_seg  = {1'b0, seg_q} == nseg_q - 1'b1;
  assign nxt_seg   = last_seg ? '0 : seg_q + 1'b1;
  assign nxt_start = start_q[int'(nxt_seg)*AW +: AW];
  assign more      = !stop_q && (!last_seg || cont_q || rep_q != '0);
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    end_d   = end_q;
    nseg_d  = nseg_q;
    rep_d   = rep_q;
    cont_d  = cont_q;
    stop_d  = stop_q | (state_q == ST_RUN && stop);
    seg_d   = seg_q;
    addr_d  = addr_q;
    raddr_d = raddr_q;
    v1_d    = 1'b0;
    l1_d    = l1_q;
    s1_d    = s1_q;
    v2_d    = v1_q;
    l2_d    = l1_q;
    s2_d    = s1_q;
    case (state_q)
      ST_IDLE: if (trigger) begin
        start_d = cfg_start;
        end_d   = cfg_end;
        nseg_d  = (cfg_nseg == '0) ? (SEG_W+1)'(1) :
                  (cfg_nseg > (SEG_W+1)'(NUM_SEG)) ? (SEG_W+1)'(NUM_SEG) : cfg_nseg;
        rep_d   = cfg_repeat;
        cont_d  = cfg_continuous;
        stop_d  = 1'b0;
        seg_d   = '0;
        addr_d  = cfg_start[AW-1:0];
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!seg_empty && can_issue) begin
          v1_d    = 1'b1;
          raddr_d = addr_q;
          l1_d    = at_end;
          s1_d    = seg_q;
          addr_d  = addr_q + 1'b1;
        end
        // Segment boundary: either the final read was just issued or the segment is empty.
        if (seg_empty || (can_issue && at_end)) begin
          if (more) begin
            seg_d  = nxt_seg;
            addr_d = nxt_start;
            rep_d  = last_seg ? rep_q - 1'b1 : rep_q;
          end else state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (fifo_cnt == 2'd0 && !v1_q && !v2_q) state_d = ST_DONE;
      ST_DONE:  if (m_axis_done_tready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      start_q <= '0;
      end_q   <= '0;
      nseg_q  <= '0;
      rep_q   <= '0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      seg_q   <= '0;
      addr_q  <= '0;
      raddr_q <= '0;
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      s1_q    <= '0;
      v2_q    <= 1'b0;
      l2_q    <= 1'b0;
      s2_q    <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      end_q   <= end_d;
      nseg_q  <= nseg_d;
      rep_q   <= rep_d;
      cont_q  <= cont_d;
      stop_q  <= stop_d;
      seg_q   <= seg_d;
      addr_q  <= addr_d;
      raddr_q <= raddr_d;
      v1_q    <= v1_d;
      l1_q    <= l1_d;
      s1_q    <= s1_d;
      v2_q    <= v2_d;
      l2_q    <= l2_d;
      s2_q    <= s2_d;
    end
  end
  assign m_axis_tvalid      = fifo_valid & ~areset;
  assign m_axis_tdata       = areset ? '0 : AXIS_TDATA_WIDTH'(fifo_data[FW-1 -: BRAM_DATA_WIDTH]);
  assign m_axis_tlast       = fifo_data[SEG_W] & ~areset;
  assign m_axis_tuser       = areset ? '0 : fifo_data[SEG_W-1:0];
  assign m_axis_done_tvalid = (state_q == ST_DONE) & ~areset;
  assign sts_busy           = (state_q != ST_IDLE) & ~areset;
  assign sts_seg            = areset ? '0 : seg_q;
  assign sts_addr           = areset ? '0 : addr_q;
  assign bram_porta_clk     = aclk;
  assign bram_porta_rst     = areset;
  assign bram_porta_addr    = areset ? '0 : raddr_q;
endmodule

// File: tb/tb_axis_multiseg_bram_reader.sv
// tb_axis_multiseg_bram_reader: table-driven runs with a beat scoreboard, plus a mid-run reset sequence.
module tb_axis_multiseg_bram_reader;
  localparam int AW = 10, DW = 32, NS = 4, SW = 2, RW = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic areset;
  logic [NS*AW-1:0] cfg_start, cfg_end;
  logic [SW:0] cfg_nseg;
  logic [RW-1:0] cfg_repeat;
  logic cfg_continuous, trigger, stop, m_axis_tready, m_axis_done_tready;
  logic [DW-1:0] m_axis_tdata, bram_rddata;
  logic m_axis_tvalid, m_axis_tlast, m_axis_done_tvalid, sts_busy, bram_clk, bram_rst;
  logic [SW-1:0] m_axis_tuser, sts_seg;
  logic [AW-1:0] sts_addr, bram_addr;

  axis_multiseg_bram_reader #(
    .AXIS_TDATA_WIDTH(DW), .BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .NUM_SEG(NS), .REP_WIDTH(RW)
  ) dut (
    .aclk(clk), .areset(areset),
    .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_nseg(cfg_nseg), .cfg_repeat(cfg_repeat),
    .cfg_continuous(cfg_continuous), .trigger(trigger), .stop(stop),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_done_tvalid(m_axis_done_tvalid), .m_axis_done_tready(m_axis_done_tready),
    .sts_busy(sts_busy), .sts_seg(sts_seg), .sts_addr(sts_addr),
    .bram_porta_clk(bram_clk), .bram_porta_rst(bram_rst),
    .bram_porta_addr(bram_addr), .bram_porta_rddata(bram_rddata)
  );

  function automatic logic [31:0] word(input logic [9:0] a);
    return {6'h2A, a, 6'h15, a};
  endfunction
  always @(posedge clk) bram_rddata <= word(bram_addr);

  function automatic logic [39:0] pk(input int a, input int b, input int c, input int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  typedef struct packed {logic [31:0] d; logic l; logic [1:0] u;} beat_t;
  typedef struct {
    logic [39:0] st;
    logic [39:0] en;
    logic [2:0]  nseg;
    logic [7:0]  rep;
    logic        cont;
    logic        rnd;
    int          stop_seg;
    int          exp_beats;
    int          exp_lasts;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];
  beat_t exp_q[$];
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic build_exp(input vec_t v);
    int n, passes;
    logic [9:0] s0, e0;
    n = (v.nseg == 3'd0) ? 1 : ((int'(v.nseg) > NS) ? NS : int'(v.nseg));
    passes = v.cont ? 1 : int'(v.rep) + 1;
    for (int p = 0; p < passes; p++)
      for (int s = 0; s < n; s++) begin
        s0 = v.st[s*AW +: AW];
        e0 = v.en[s*AW +: AW];
        for (int a = int'(s0); a <= int'(e0); a++)
          exp_q.push_back({word(10'(a)), 10'(a) == e0, 2'(s)});
        if (s == v.stop_seg) return;
      end
  endtask

  task automatic run_case(input string nm, input vec_t v);
    int cyc, lat, beats, lasts, dones;
    bit stall, stop_sent, done_acc;
    beat_t cur, held, e;
    build_exp(v);
    cyc = 0; lat = -1; beats = 0; lasts = 0; dones = 0;
    stall = 1'b0; stop_sent = 1'b0; done_acc = 1'b0; held = '0;
    @(negedge clk);
    cfg_start = v.st; cfg_end = v.en; cfg_nseg = v.nseg; cfg_repeat = v.rep;
    cfg_continuous = v.cont; trigger = 1'b1; m_axis_tready = 1'b1; m_axis_done_tready = 1'b0;
    while (!done_acc && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      trigger = 1'b0;
      stop = 1'b0;
      if (cyc == 1) chk({nm, "_busy"}, 64'(sts_busy), 64'd1);
      cur = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
      if (stall) chk({nm, "_hold"}, 64'({m_axis_tvalid, cur}), 64'({1'b1, held}));
      if (m_axis_tvalid && lat < 0) lat = cyc - 1;
      m_axis_tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        lasts += int'(m_axis_tlast);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({nm, "_beat"}, 64'(cur), 64'(e));
        end
      end
      stall = m_axis_tvalid && !m_axis_tready;
      held = cur;
      if (v.stop_seg >= 0 && !stop_sent && m_axis_tvalid && int'(m_axis_tuser) == v.stop_seg) begin
        stop = 1'b1;
        stop_sent = 1'b1;
      end
      m_axis_done_tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axis_done_tvalid && m_axis_done_tready) begin
        dones++;
        done_acc = 1'b1;
      end
    end
    chk({nm, "_done_in_time"}, 64'(done_acc), 64'd1);
    repeat (6) begin
      @(negedge clk);
      stop = 1'b0;
      m_axis_tready = 1'b1;
      m_axis_done_tready = 1'b1;
      if (m_axis_done_tvalid) dones++;
      if (m_axis_tvalid) beats++;
    end
    chk({nm, "_beats"}, 64'(beats), 64'(v.exp_beats));
    chk({nm, "_lasts"}, 64'(lasts), 64'(v.exp_lasts));
    chk({nm, "_dones"}, 64'(dones), 64'd1);
    chk({nm, "_first_valid_lat"}, 64'(lat), 64'(v.exp_lat));
    chk({nm, "_left_in_queue"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_idle"}, 64'(sts_busy), 64'd0);
    exp_q.delete();
  endtask

  task automatic reset_mid_run();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    cfg_start = pk(5, 0, 0, 0); cfg_end = pk(40, 0, 0, 0); cfg_nseg = 3'd1; cfg_repeat = 8'd0;
    cfg_continuous = 1'b0; trigger = 1'b1; m_axis_tready = 1'b0; m_axis_done_tready = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      trigger = 1'b0;
      seen = m_axis_tvalid;
    end
    chk("rstmid_valid_seen", 64'(seen), 64'd1);
    areset = 1'b1;
    #1;
    chk("rstmid_tvalid_in_reset", 64'(m_axis_tvalid), 64'd0);
    @(negedge clk);
    areset = 1'b0;
    chk("rstmid_tvalid_next", 64'(m_axis_tvalid), 64'd0);
    chk("rstmid_busy_next", 64'(sts_busy), 64'd0);
    chk("rstmid_done_next", 64'(m_axis_done_tvalid), 64'd0);
    repeat (4) @(negedge clk);
    chk("rstmid_no_stale_beat", 64'(m_axis_tvalid), 64'd0);
    run_case("restart", vecs[1]);
  endtask

  initial begin
    areset = 1'b1; cfg_start = '0; cfg_end = '0; cfg_nseg = '0; cfg_repeat = '0;
    cfg_continuous = 1'b0; trigger = 1'b0; stop = 1'b0; m_axis_tready = 1'b0; m_axis_done_tready = 1'b0;
    //          start               end                    nseg  rep   cont  rnd   stop beats lasts lat
    vecs[0] = '{pk(5, 0, 0, 0),      pk(8, 0, 0, 0),       3'd1, 8'd0, 1'b0, 1'b0, -1,  4,  1,  3};
    vecs[1] = '{pk(0, 10, 0, 0),     pk(1, 12, 0, 0),      3'd2, 8'd1, 1'b0, 1'b0, -1, 10,  4,  3};
    vecs[2] = '{pk(0, 10, 0, 0),     pk(1, 12, 0, 0),      3'd2, 8'd1, 1'b0, 1'b1, -1, 10,  4,  3};
    vecs[3] = '{pk(0, 20, 50, 0),    pk(3, 39, 52, 0),     3'd3, 8'd0, 1'b1, 1'b0,  1, 24,  2,  3};
    vecs[4] = '{pk(9, 1020, 0, 0),   pk(4, 1023, 0, 0),    3'd2, 8'd0, 1'b0, 1'b0, -1,  4,  1,  4};
    vecs[5] = '{pk(3, 7, 0, 0),      pk(2, 1, 0, 0),       3'd2, 8'd2, 1'b0, 1'b0, -1,  0,  0, -1};
    vecs[6] = '{pk(2, 100, 0, 0),    pk(3, 101, 0, 0),     3'd0, 8'd0, 1'b0, 1'b0, -1,  2,  1,  3};
    vecs[7] = '{pk(0, 1, 3, 4),      pk(0, 2, 3, 5),       3'd7, 8'd0, 1'b0, 1'b0, -1,  6,  4,  3};
    vecs[8] = '{pk(100, 200, 300, 1022), pk(104, 200, 302, 1023), 3'd4, 8'd2, 1'b0, 1'b1, -1, 33, 12, 3};
    repeat (3) @(negedge clk);
    chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("reset_done", 64'(m_axis_done_tvalid), 64'd0);
    chk("reset_busy", 64'(sts_busy), 64'd0);
    chk("reset_bram_rst", 64'(bram_rst), 64'd1);
    chk("reset_bram_addr", 64'(bram_addr), 64'd0);
    chk("reset_tdata", 64'(m_axis_tdata), 64'd0);
    areset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 64'(sts_busy), 64'd0);
    for (int i = 0; i < 9; i++) run_case($sformatf("v%0d", i), vecs[i]);
    reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
